// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and helpers for the tri-state bus arbiter: FSM state encoding,
// turnaround length and a reference round-robin search.
package tri_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_TURN = 2'd1,
    ARB_OWN  = 2'd2
  } arb_state_e;

  localparam int TURN_CYCLES = 1;
  localparam int MAX_REQ     = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit at or after ptr, wrapping at nreq; lowest offset wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [3:0]         ptr,
                                       input int                 nreq);
    rr_pick_t   res;
    logic [3:0] pos;
    res = '0;
    pos = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        pos = 4'((int'(ptr) + k) % nreq);
        if (req[pos]) begin
          res.valid = 1'b1;
          res.idx   = pos;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so ptr sits at
// bit 0, priority-encode the lowest set bit, then rotate the index back.
module rr_picker #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  localparam int DW = IDW + 1;

  logic [2*NREQ-1:0] dbl;
  logic [DW-1:0]     ptr_ext;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    off;
  logic [DW-1:0]     sum;

  always_comb begin
    dbl     = {req, req};
    ptr_ext = {1'b0, ptr};
    rot     = dbl[ptr_ext +: NREQ];
    off     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    valid = |req;
    sum   = ptr_ext + {1'b0, off};
    if (sum >= DW'(NREQ)) sum = sum - DW'(NREQ);
    idx   = sum[IDW-1:0];
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared pull-up bus: grant, one turnaround
// cycle with every driver off, then tenure until done, request drop or timeout.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int HOLD_MAX = 8,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] oe,
  output logic [IDW-1:0]  owner,
  output logic            bus_busy,
  output logic            preempt
);

  localparam int             HW        = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [HW-1:0]  HOLD_SAT  = HW'(HOLD_MAX);

  arb_state_e      state, state_nxt;
  logic [NREQ-1:0] gnt_nxt, oe_nxt;
  logic [IDW-1:0]  owner_nxt, rr_ptr, rr_ptr_nxt, owner_inc, pick_ptr, pick_idx;
  logic            busy_nxt, preempt_nxt, pick_valid;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic            own_req, own_done, others, hold_expired;
  rr_pick_t        ref_pick;

  // gnt is the owner's one-hot in TURN/OWN, so it doubles as the owner mask
  assign own_req   = |(req & gnt);
  assign own_done  = |(done & gnt);
  assign others    = |(req & ~gnt);
  assign owner_inc = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);
  assign pick_ptr  = (state == ARB_OWN) ? owner_inc : rr_ptr;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    oe_nxt       = oe;
    owner_nxt    = owner;
    busy_nxt     = bus_busy;
    preempt_nxt  = 1'b0;
    rr_ptr_nxt   = rr_ptr;
    hold_nxt     = hold_cnt;
    hold_expired = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_nxt = ARB_TURN;
          gnt_nxt   = NREQ'(1) << pick_idx;
          owner_nxt = pick_idx;
          busy_nxt  = 1'b1;
          oe_nxt    = '0;
        end
      end
      ARB_TURN: begin
        if (own_req) begin
          state_nxt = ARB_OWN;
          oe_nxt    = gnt;
          hold_nxt  = '0;
        end else begin
          state_nxt = ARB_IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end
      end
      ARB_OWN: begin
        if (others && hold_cnt != HOLD_SAT) hold_nxt = hold_cnt + HW'(1);
        hold_expired = others && (hold_cnt == HOLD_LAST);
        // done and request drop take precedence over the timeout
        if (own_done || !own_req || hold_expired) begin
          preempt_nxt = hold_expired && own_req && !own_done;
          oe_nxt      = '0;
          rr_ptr_nxt  = owner_inc;
          if (pick_valid) begin
            state_nxt = ARB_TURN;
            gnt_nxt   = NREQ'(1) << pick_idx;
            owner_nxt = pick_idx;
          end else begin
            state_nxt = ARB_IDLE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = '0;
        oe_nxt    = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      gnt      <= '0;
      oe       <= '0;
      owner    <= '0;
      bus_busy <= 1'b0;
      preempt  <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      oe       <= oe_nxt;
      owner    <= owner_nxt;
      bus_busy <= busy_nxt;
      preempt  <= preempt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb ref_pick = rr_pick(MAX_REQ'(req), 4'(pick_ptr), NREQ);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_oe_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(oe));
  a_oe_is_gnt:  assert property (@(posedge clk) disable iff (!rst_n) (oe != '0) |-> (oe == gnt));
  a_oe_own:     assert property (@(posedge clk) disable iff (!rst_n) (state != ARB_OWN) |-> (oe == '0));
  a_turn_len:   assert property (@(posedge clk) disable iff (!rst_n)
                                 (state == ARB_TURN && TURN_CYCLES == 1) |=> (state != ARB_TURN));
  a_picker:     assert property (@(posedge clk) disable iff (!rst_n)
                                 (pick_valid == ref_pick.valid) &&
                                 (!pick_valid || 4'(pick_idx) == ref_pick.idx));

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter: directed scenarios plus a randomized
// run against a spec-level behavioural model.
module tb_tri_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int HOLD_MAX = 8;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] oe;
  logic [1:0]      owner;
  logic            bus_busy;
  logic            preempt;

  int total = 0;
  int bad   = 0;

  tri_bus_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .oe       (oe),
    .owner    (owner),
    .bus_busy (bus_busy),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Spec rule: first pending requester at or after ptr, wrapping around.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (oe !== 4'b0000) begin bad++; $display("[TB] FAIL reset_oe got=%b want=0000", oe); end
    total++; if (owner !== 2'd0) begin bad++; $display("[TB] FAIL reset_owner got=%0d want=0", owner); end
    total++; if (bus_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus_busy); end
    total++; if (preempt !== 1'b0) begin bad++; $display("[TB] FAIL reset_preempt got=%b want=0", preempt); end
  endtask

  task automatic test_single_latency;
    apply_reset();
    req = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("[TB] FAIL lat_gnt got=%b want=0100", gnt); end
    total++; if (owner !== 2'd2) begin bad++; $display("[TB] FAIL lat_owner got=%0d want=2", owner); end
    total++; if (oe !== 4'b0000) begin bad++; $display("[TB] FAIL lat_oe_turn got=%b want=0000", oe); end
    total++; if (bus_busy !== 1'b1) begin bad++; $display("[TB] FAIL lat_busy got=%b want=1", bus_busy); end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (oe !== 4'b0100) begin bad++; $display("[TB] FAIL lat_oe_own c=%0d got=%b want=0100", c, oe); end
    end
    req = '0;
    tick();
    total++; if (oe !== 4'b0000) begin bad++; $display("[TB] FAIL lat_release_oe got=%b want=0000", oe); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL lat_release_gnt got=%b want=0000", gnt); end
  endtask

  task automatic test_round_robin;
    int exp;
    logic [NREQ-1:0] bit_e;
    apply_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp   = n % NREQ;
      bit_e = NREQ'(1) << exp;
      tick();
      done = '0;
      total++; if (gnt !== bit_e) begin bad++; $display("[TB] FAIL rr_gnt n=%0d got=%b want=%b", n, gnt, bit_e); end
      total++; if (oe !== 4'b0000) begin bad++; $display("[TB] FAIL rr_gap_oe n=%0d got=%b want=0000", n, oe); end
      total++; if (int'(owner) != exp) begin bad++; $display("[TB] FAIL rr_owner n=%0d got=%0d want=%0d", n, owner, exp); end
      for (int k = 1; k <= 3; k++) begin
        tick();
        total++; if (oe !== bit_e) begin bad++; $display("[TB] FAIL rr_oe n=%0d k=%0d got=%b want=%b", n, k, oe, bit_e); end
        if (k == 3) done = bit_e;
      end
    end
    req = '0;
    tick();
    done = '0;
    total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL rr_end_gnt got=%b want=0000", gnt); end
  endtask

  task automatic test_preempt;
    apply_reset();
    req = 4'b0011;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL pre_first_gnt got=%b want=0001", gnt); end
    for (int c = 1; c <= HOLD_MAX; c++) begin
      tick();
      total++; if (oe !== 4'b0001) begin bad++; $display("[TB] FAIL pre_oe c=%0d got=%b want=0001", c, oe); end
      total++; if (preempt !== 1'b0) begin bad++; $display("[TB] FAIL pre_early c=%0d got=%b want=0", c, preempt); end
    end
    tick();
    total++; if (preempt !== 1'b1) begin bad++; $display("[TB] FAIL pre_pulse got=%b want=1", preempt); end
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL pre_next_gnt got=%b want=0010", gnt); end
    total++; if (oe !== 4'b0000) begin bad++; $display("[TB] FAIL pre_turn_oe got=%b want=0000", oe); end
    tick();
    total++; if (preempt !== 1'b0) begin bad++; $display("[TB] FAIL pre_one_cycle got=%b want=0", preempt); end
    total++; if (oe !== 4'b0010) begin bad++; $display("[TB] FAIL pre_new_oe got=%b want=0010", oe); end
  endtask

  task automatic test_done_vs_preempt;
    apply_reset();
    req = 4'b0011;
    tick();
    repeat (HOLD_MAX) tick();
    done = 4'b0001;
    tick();
    done = '0;
    total++; if (preempt !== 1'b0) begin bad++; $display("[TB] FAIL dvp_preempt got=%b want=0", preempt); end
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL dvp_gnt got=%b want=0010", gnt); end
  endtask

  task automatic test_turn_drop;
    logic [NREQ-1:0] seen_oe;
    apply_reset();
    req = 4'b0010;
    tick();
    seen_oe = oe;
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL drop_turn_gnt got=%b want=0010", gnt); end
    req = '0;
    tick();
    seen_oe = seen_oe | oe;
    total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL drop_gnt got=%b want=0000", gnt); end
    total++; if (bus_busy !== 1'b0) begin bad++; $display("[TB] FAIL drop_busy got=%b want=0", bus_busy); end
    tick();
    seen_oe = seen_oe | oe;
    total++; if (seen_oe !== 4'b0000) begin bad++; $display("[TB] FAIL drop_oe_seen got=%b want=0000", seen_oe); end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    req = 4'b0001;
    tick();
    tick();
    total++; if (oe !== 4'b0001) begin bad++; $display("[TB] FAIL b2b_first_oe got=%b want=0001", oe); end
    done = 4'b0001;
    tick();
    done = '0;
    total++; if (oe !== 4'b0000) begin bad++; $display("[TB] FAIL b2b_turn_oe got=%b want=0000", oe); end
    total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL b2b_regrant got=%b want=0001", gnt); end
    tick();
    total++; if (oe !== 4'b0001) begin bad++; $display("[TB] FAIL b2b_second_oe got=%b want=0001", oe); end
  endtask

  task automatic test_async_reset;
    apply_reset();
    req = 4'b0001;
    tick();
    tick();
    total++; if (oe !== 4'b0001) begin bad++; $display("[TB] FAIL ar_pre_oe got=%b want=0001", oe); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (oe !== 4'b0000) begin bad++; $display("[TB] FAIL ar_oe got=%b want=0000", oe); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL ar_gnt got=%b want=0000", gnt); end
    req = 4'b1000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("[TB] FAIL ar_regrant got=%b want=1000", gnt); end
    total++; if (owner !== 2'd3) begin bad++; $display("[TB] FAIL ar_owner got=%0d want=3", owner); end
  endtask

  task automatic test_random(input int ncycles);
    int m_st, m_own, m_ptr, m_hold;
    bit m_pre, others, ended;
    logic [NREQ-1:0] r, d, e_gnt, e_oe;
    int wait_c[NREQ];
    int bound;
    bound = (NREQ - 1) * (HOLD_MAX + 1) + 1;
    apply_reset();
    m_st = 0; m_own = 0; m_ptr = 0; m_hold = 0;
    r = '0;
    for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
    for (int cyc = 0; cyc < ncycles; cyc++) begin
      d = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (!r[i]) begin
          if ($urandom_range(3) == 0) r[i] = 1'b1;
        end else if (m_st == 2 && m_own == i) begin
          if ($urandom_range(7) == 0) r[i] = 1'b0;
          else if ($urandom_range(5) == 0) d[i] = 1'b1;
        end
        if (!(m_st == 2 && m_own == i) && $urandom_range(9) == 0) d[i] = 1'b1;
      end
      req  = r;
      done = d;
      @(posedge clk);
      m_pre = 1'b0;
      case (m_st)
        0: if (r != '0) begin m_own = model_pick(r, m_ptr); m_st = 1; end
        1: if (r[m_own]) begin m_st = 2; m_hold = 0; end else m_st = 0;
        default: begin
          others = (r & ~(NREQ'(1) << m_own)) != '0;
          if (others && m_hold < HOLD_MAX) m_hold++;
          ended = d[m_own] || !r[m_own] || (others && m_hold == HOLD_MAX);
          if (ended) begin
            m_pre = !d[m_own] && r[m_own];
            m_ptr = (m_own + 1) % NREQ;
            if (r != '0) begin m_own = model_pick(r, m_ptr); m_st = 1; end
            else m_st = 0;
          end
        end
      endcase
      #1;
      e_gnt = (m_st != 0) ? (NREQ'(1) << m_own) : '0;
      e_oe  = (m_st == 2) ? (NREQ'(1) << m_own) : '0;
      total++; if (gnt !== e_gnt) begin bad++; $display("[TB] FAIL rnd_gnt cyc=%0d got=%b want=%b", cyc, gnt, e_gnt); end
      total++; if (oe !== e_oe) begin bad++; $display("[TB] FAIL rnd_oe cyc=%0d got=%b want=%b", cyc, oe, e_oe); end
      total++; if (int'(owner) != m_own) begin bad++; $display("[TB] FAIL rnd_owner cyc=%0d got=%0d want=%0d", cyc, owner, m_own); end
      total++; if (bus_busy !== (m_st != 0)) begin bad++; $display("[TB] FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, bus_busy, m_st != 0); end
      total++; if (preempt !== m_pre) begin bad++; $display("[TB] FAIL rnd_preempt cyc=%0d got=%b want=%b", cyc, preempt, m_pre); end
      for (int i = 0; i < NREQ; i++) begin
        if (r[i] && !gnt[i]) wait_c[i]++;
        else wait_c[i] = 0;
        total++;
        if (wait_c[i] > bound) begin
          bad++;
          $display("[TB] FAIL rnd_starve req=%0d cyc=%0d waited=%0d limit=%0d", i, cyc, wait_c[i], bound);
          wait_c[i] = 0;
        end
      end
    end
    req  = '0;
    done = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    test_reset();
    test_single_latency();
    test_round_robin();
    test_preempt();
    test_done_vs_preempt();
    test_turn_drop();
    test_back_to_back();
    test_async_reset();
    test_random(10000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
